// File: rtl/sr04_echo_timer_if.sv
// Result bus from the HC-SR04 echo timer to the distance stage.
// TIME: echo width in ticks, VALID: one-cycle update strobe, TOUT: timeout flag.
interface sr04_echo_timer_if;
    logic [15:0] TIME;
    logic        VALID;
    logic        TOUT;

    modport master (
        output TIME,
        output VALID,
        output TOUT
    );

    modport slave (
        input TIME,
        input VALID,
        input TOUT
    );
endinterface

// File: rtl/sr04_echo_timer.sv
// HC-SR04 trigger sequencer and echo-width timer; echo width in ~1 MHz ticks.
// Ports: CLK, RST (async active-low), ECHO in, TRIG out, bus = result (TIME/VALID/TOUT).
// Optional ECHO_FILTER_EN: 4-cycle glitch filter on the synchronised echo.
module sr04_echo_timer #(
    parameter int unsigned TICK_DIV     = 98,
    parameter int unsigned TRIG_TICKS   = 11,
    parameter int unsigned PERIOD_TICKS = 61440,
    parameter int unsigned RISE_MAX     = 4096,
    parameter int unsigned ECHO_MAX     = 24576
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ECHO,
    output logic                  TRIG,
    sr04_echo_timer_if.master     bus
);

    localparam logic [6:0]  DIV_LAST  = 7'(TICK_DIV - 1);
    localparam logic [15:0] TRIG_LAST = 16'(TRIG_TICKS - 1);
    localparam logic [15:0] PER_LAST  = 16'(PERIOD_TICKS - 1);
    localparam logic [15:0] RISE_LAST = 16'(RISE_MAX - 1);
    localparam logic [15:0] ECHO_LIM  = 16'(ECHO_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t      state;
    logic        echo_m;
    logic        echo_q;
    logic        echo_s;
    logic        echo_d;
    logic        echo_rise;
    logic        echo_fall;
    logic        echo_accept;
    logic [6:0]  div_cnt;
    logic        tick;
    logic [15:0] per_cnt;
    logic [15:0] phase_cnt;
    logic [15:0] width_cnt;

    // Two-flop synchroniser for the asynchronous sensor pin.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            echo_m <= 1'b0;
            echo_q <= 1'b0;
        end else begin
            echo_m <= ECHO;
            echo_q <= echo_m;
        end
    end

`ifdef ECHO_FILTER_EN
    localparam int unsigned FILT_LEN  = 4;
    localparam logic [2:0]  FILT_LAST = 3'(FILT_LEN - 1);

    logic [2:0] filt_cnt;
    logic       echo_f;

    // The filtered level follows only after FILT_LEN consecutive
    // cycles of disagreement, so both edges shift by FILT_LEN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            filt_cnt <= 3'd0;
            echo_f   <= 1'b0;
        end else if (echo_q == echo_f) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_cnt <= 3'd0;
            echo_f   <= echo_q;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign echo_s = echo_f;
`else
    assign echo_s = echo_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            echo_d <= 1'b0;
        end else begin
            echo_d <= echo_s;
        end
    end

    assign echo_rise   = echo_s & ~echo_d;
    assign echo_fall   = ~echo_s & echo_d;
    assign echo_accept = (state == ST_WAIT_RISE) && echo_rise;

    // Tick divider; restarted on the accepted rising edge so the
    // width measurement is phase-aligned to the echo.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt <= 7'd0;
        end else if (echo_accept || div_cnt == DIV_LAST) begin
            div_cnt <= 7'd0;
        end else begin
            div_cnt <= div_cnt + 7'd1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Sequencer, period counter and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            TRIG      <= 1'b0;
            bus.VALID <= 1'b0;
            bus.TIME  <= 16'h0000;
            bus.TOUT  <= 1'b0;
            per_cnt   <= 16'd0;
            phase_cnt <= 16'd0;
            width_cnt <= 16'd0;
        end else begin
            bus.VALID <= 1'b0;

            if (tick && per_cnt != PER_LAST) begin
                per_cnt <= per_cnt + 16'd1;
            end

            unique case (state)
                ST_IDLE: begin
                    // Hold off while the sensor still drives echo high.
                    if (per_cnt == PER_LAST && !echo_s) begin
                        state     <= ST_TRIG;
                        TRIG      <= 1'b1;
                        per_cnt   <= 16'd0;
                        phase_cnt <= 16'd0;
                    end
                end

                ST_TRIG: begin
                    if (tick) begin
                        if (phase_cnt == TRIG_LAST) begin
                            state     <= ST_WAIT_RISE;
                            TRIG      <= 1'b0;
                            phase_cnt <= 16'd0;
                        end else begin
                            phase_cnt <= phase_cnt + 16'd1;
                        end
                    end
                end

                ST_WAIT_RISE: begin
                    if (echo_rise) begin
                        state     <= ST_MEASURE;
                        width_cnt <= 16'd0;
                    end else if (tick) begin
                        if (phase_cnt == RISE_LAST) begin
                            state     <= ST_DONE;
                            bus.VALID <= 1'b1;
                            bus.TIME  <= 16'hFFFF;
                            bus.TOUT  <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 16'd1;
                        end
                    end
                end

                ST_MEASURE: begin
                    if (width_cnt == ECHO_LIM) begin
                        state     <= ST_DONE;
                        bus.VALID <= 1'b1;
                        bus.TIME  <= 16'hFFFF;
                        bus.TOUT  <= 1'b1;
                    end else if (echo_fall) begin
                        state     <= ST_DONE;
                        bus.VALID <= 1'b1;
                        bus.TIME  <= width_cnt;
                        bus.TOUT  <= 1'b0;
                    end else if (tick && echo_s) begin
                        width_cnt <= width_cnt + 16'd1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    a_valid_pulse: assert property (
        @(posedge CLK) disable iff (!RST)
        bus.VALID |=> !bus.VALID
    );

    a_valid_done: assert property (
        @(posedge CLK) disable iff (!RST)
        bus.VALID == (state == ST_DONE)
    );

    a_trig_state: assert property (
        @(posedge CLK) disable iff (!RST)
        TRIG == (state == ST_TRIG)
    );

    a_width_bound: assert property (
        @(posedge CLK) disable iff (!RST)
        width_cnt <= ECHO_LIM
    );

endmodule

// File: tb/tb_sr04_echo_timer.sv
// Randomised self-checking bench for sr04_echo_timer with scaled-down timing.
// Expectations come from tick arithmetic: width/TICK_DIV, timeout windows, periods.
module tb_sr04_echo_timer;

    localparam int D = 4;
    localparam int T = 3;
    localparam int P = 200;
    localparam int R = 40;
    localparam int E = 60;
`ifdef ECHO_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic echo = 1'b0;
    logic trig;

    sr04_echo_timer_if bus ();

    sr04_echo_timer #(
        .TICK_DIV    (D),
        .TRIG_TICKS  (T),
        .PERIOD_TICKS(P),
        .RISE_MAX    (R),
        .ECHO_MAX    (E)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .ECHO(echo),
        .TRIG(trig),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int vcount = 0;

    always @(posedge clk) begin
        if (bus.VALID === 1'b1) vcount <= vcount + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trig(input logic lvl, input int max,
                             output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < max) begin
            @(negedge clk);
            cycles++;
            if (trig === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int max, output int cycles,
                              output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < max) begin
            @(negedge clk);
            cycles++;
            if (bus.VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Advance to the start of the next WAIT_RISE window.
    task automatic sync_next();
        int  c;
        bit  ok;
        bit  ok2;
        wait_trig(1'b1, (P + T + 10) * D, c, ok);
        wait_trig(1'b0, (T + 2) * D, c, ok2);
        n_checks++;
        if (!(ok && ok2)) begin
            n_fail++;
            $display("FAIL sync_next: trigger cycle not seen (rise %0b fall %0b), required both 1",
                     ok, ok2);
        end
    endtask

    task automatic test_reset();
        int c;
        bit ok;
        rst_n = 1'b0;
        echo = 1'b0;
        cyc(5);
        n_checks++;
        if (trig !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_trig: got %b, required 0", trig);
        end
        n_checks++;
        if (bus.VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid: got %b, required 0", bus.VALID);
        end
        n_checks++;
        if (bus.TIME !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_time: got %h, required 0000", bus.TIME);
        end
        n_checks++;
        if (bus.TOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_tout: got %b, required 0", bus.TOUT);
        end
        rst_n = 1'b1;
        wait_trig(1'b1, (P + 2) * D, c, ok);
        n_checks++;
        if (!ok || c < (P - 1) * D || c > (P + 1) * D) begin
            n_fail++;
            $display("FAIL first_trig: rose after %0d cycles (seen %0b), required %0d +/- %0d",
                     c, ok, P * D, D);
        end
        wait_trig(1'b0, (T + 2) * D, c, ok);
        n_checks++;
        if (!ok || c < (T - 1) * D || c > T * D + 1) begin
            n_fail++;
            $display("FAIL trig_width: high for %0d cycles (fell %0b), required %0d +/- %0d",
                     c, ok, T * D, D);
        end
    endtask

    task automatic test_measure(input int iters);
        int c;
        bit ok;
        int dly;
        int w;
        int exp_t;
        int got;
        int v0;
        for (int i = 0; i < iters; i++) begin
            dly = $urandom_range(2, (R / 2) * D);
            w = $urandom_range(2 * D, (E - 4) * D);
            exp_t = w / D;
            cyc(dly);
            v0 = vcount;
            echo = 1'b1;
            cyc(w);
            echo = 1'b0;
            wait_valid(20 + FL, c, ok);
            got = int'(bus.TIME);
            n_checks++;
            if (!ok || c < 2 + FL || c > 4 + FL) begin
                n_fail++;
                $display("FAIL fall_to_valid: %0d cycles (seen %0b), required %0d..%0d",
                         c, ok, 2 + FL, 4 + FL);
            end
            n_checks++;
            if (got < exp_t - 1 || got > exp_t + 1) begin
                n_fail++;
                $display("FAIL meas_time: width %0d cycles gave %0d, required %0d +/- 1",
                         w, got, exp_t);
            end
            n_checks++;
            if (bus.TOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL meas_tout: got %b, required 0", bus.TOUT);
            end
            cyc(2);
            n_checks++;
            if (vcount - v0 != 1) begin
                n_fail++;
                $display("FAIL meas_valid_once: %0d strobes, required 1",
                         vcount - v0);
            end
            sync_next();
        end
    endtask

    task automatic test_no_echo();
        int c;
        bit ok;
        wait_valid(R * D + 20, c, ok);
        n_checks++;
        if (!ok || c < (R - 1) * D || c > R * D + 4) begin
            n_fail++;
            $display("FAIL rise_timeout: valid after %0d cycles (seen %0b), required about %0d",
                     c, ok, R * D);
        end
        n_checks++;
        if (bus.TIME !== 16'hFFFF || bus.TOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_timeout_val: time %h tout %b, required ffff 1",
                     bus.TIME, bus.TOUT);
        end
        sync_next();
    endtask

    task automatic test_stuck_high();
        int c;
        bit ok;
        bit trig_seen;
        cyc(10);
        echo = 1'b1;
        wait_valid((E + 2) * D + 20, c, ok);
        n_checks++;
        if (!ok || c < (E - 1) * D || c > (E + 1) * D + 10) begin
            n_fail++;
            $display("FAIL echo_timeout: valid after %0d cycles (seen %0b), required about %0d",
                     c, ok, E * D);
        end
        n_checks++;
        if (bus.TIME !== 16'hFFFF || bus.TOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL echo_timeout_val: time %h tout %b, required ffff 1",
                     bus.TIME, bus.TOUT);
        end
        trig_seen = 1'b0;
        for (int i = 0; i < P * D; i++) begin
            @(negedge clk);
            if (trig !== 1'b0) trig_seen = 1'b1;
        end
        n_checks++;
        if (trig_seen) begin
            n_fail++;
            $display("FAIL stuck_no_trig: trigger fired with echo high, required none");
        end
        echo = 1'b0;
        wait_trig(1'b1, 20, c, ok);
        n_checks++;
        if (!ok || c < 2 + FL || c > 5 + FL) begin
            n_fail++;
            $display("FAIL trig_after_fall: %0d cycles (seen %0b), required %0d..%0d",
                     c, ok, 2 + FL, 5 + FL);
        end
        wait_trig(1'b0, (T + 2) * D, c, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL trig_end: trigger stayed high, required fall");
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bit ok;
        int v0;
        cyc(5);
        echo = 1'b1;
        cyc(30);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (trig !== 1'b0 || bus.VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_ctl: trig %b valid %b, required 0 0",
                     trig, bus.VALID);
        end
        n_checks++;
        if (bus.TIME !== 16'h0000 || bus.TOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_res: time %h tout %b, required 0000 0",
                     bus.TIME, bus.TOUT);
        end
        cyc(5);
        echo = 1'b0;
        v0 = vcount;
        rst_n = 1'b1;
        wait_trig(1'b1, (P + 2) * D, c, ok);
        n_checks++;
        if (!ok || c < (P - 1) * D || c > (P + 1) * D) begin
            n_fail++;
            $display("FAIL mid_rst_trig: rose after %0d cycles (seen %0b), required %0d +/- %0d",
                     c, ok, P * D, D);
        end
        n_checks++;
        if (vcount != v0) begin
            n_fail++;
            $display("FAIL mid_rst_no_valid: %0d strobes, required 0",
                     vcount - v0);
        end
        wait_trig(1'b0, (T + 2) * D, c, ok);
    endtask

`ifdef ECHO_FILTER_EN
    task automatic test_filter();
        int c;
        bit ok;
        int got;
        cyc(3);
        echo = 1'b1;
        cyc(2);
        echo = 1'b0;
        wait_valid(R * D + 20, c, ok);
        n_checks++;
        if (!ok || bus.TOUT !== 1'b1 || bus.TIME !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL glitch_ignored: seen %0b tout %b time %h, required 1 1 ffff",
                     ok, bus.TOUT, bus.TIME);
        end
        sync_next();
        cyc(3);
        echo = 1'b1;
        cyc(10);
        echo = 1'b0;
        wait_valid(30, c, ok);
        got = int'(bus.TIME);
        n_checks++;
        if (!ok || bus.TOUT !== 1'b0 || got < 10 / D - 1 || got > 10 / D + 1) begin
            n_fail++;
            $display("FAIL pulse_accepted: seen %0b tout %b time %0d, required 1 0 %0d",
                     ok, bus.TOUT, got, 10 / D);
        end
        sync_next();
    endtask
`endif

    initial begin
        test_reset();
        test_measure(5);
        test_no_echo();
        test_stuck_high();
        test_reset_mid();
`ifdef ECHO_FILTER_EN
        test_filter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
